// File: rtl/core_c1_sb_sram.sv
// Single-port word-addressed SRAM responder on the core simple bus with configurable read/write wait states.
// Optional address range checking is enabled by defining CORE_C1_SB_SRAM_RANGE_CHK_EN.
module core_c1_sb_sram #(
    parameter int MEM_AW  = 12,
    parameter int RD_WAIT = 0,
    parameter int WR_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sb_arvalid,
    output logic        sb_arready,
    input  logic [31:0] sb_araddr,
    output logic        sb_rvalid,
    input  logic        sb_rready,
    output logic [31:0] sb_rdata,
    input  logic        sb_wvalid,
    output logic        sb_wready,
    input  logic [31:0] sb_waddr,
    input  logic [31:0] sb_wdata,
    input  logic [3:0]  sb_wstrb,
    output logic        sb_bvalid,
    input  logic        sb_bready,
    output logic        sb_bresp
);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    localparam logic [3:0] RD_CNT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
    localparam logic [3:0] WR_CNT_INIT = (WR_WAIT > 0) ? 4'(WR_WAIT - 1) : 4'd0;

    logic [31:0]       mem [0:(2**MEM_AW)-1];
    r_state_t          r_state;
    w_state_t          w_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt;
    logic [31:0]       rdata_q;
    logic [MEM_AW-1:0] r_idx;
    logic [MEM_AW-1:0] w_idx;
    logic              r_oor;
    logic              w_oor;
    logic              ar_hs;
    logic              w_hs;
    logic              unused_addr_bits;

    assign r_idx = sb_araddr[MEM_AW+1:2];
    assign w_idx = sb_waddr[MEM_AW+1:2];
    assign unused_addr_bits = ^{sb_araddr[31:MEM_AW+2], sb_araddr[1:0],
                                sb_waddr[31:MEM_AW+2], sb_waddr[1:0]};

`ifdef CORE_C1_SB_SRAM_RANGE_CHK_EN
    assign r_oor = |sb_araddr[31:MEM_AW+2];
    assign w_oor = |sb_waddr[31:MEM_AW+2];
`else
    assign r_oor = 1'b0;
    assign w_oor = 1'b0;
`endif

    // Ready re-opens in the response state only when the response drains this cycle
    // and there is no wait phase to run, giving one transfer per cycle at zero wait.
    assign sb_arready = (r_state == R_IDLE) ||
                        ((r_state == R_RESP) && sb_rready && (RD_WAIT == 0));
    assign sb_wready  = (w_state == W_IDLE) ||
                        ((w_state == W_RESP) && sb_bready && (WR_WAIT == 0));
    assign ar_hs      = sb_arvalid && sb_arready;
    assign w_hs       = sb_wvalid && sb_wready;

    assign sb_rvalid  = (r_state == R_RESP);
    assign sb_bvalid  = (w_state == W_RESP);
    assign sb_rdata   = rdata_q;

    // NOTE: the storage array has no reset; only control state and output registers do.
    always_ff @(posedge clk) begin
        if (w_hs && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (sb_wstrb[i]) mem[w_idx][8*i +: 8] <= sb_wdata[8*i +: 8];
            end
        end
    end

    // Data is captured at the AR handshake, so a same-edge write is not seen (old data returned).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_cnt   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            if (ar_hs) rdata_q <= r_oor ? 32'h0 : mem[r_idx];
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_state <= (RD_WAIT == 0) ? R_RESP : R_WAIT;
                    r_cnt   <= RD_CNT_INIT;
                end
                R_WAIT: if (r_cnt == 4'd0) r_state <= R_RESP;
                        else r_cnt <= r_cnt - 4'd1;
                R_RESP: if (sb_rready) r_state <= ar_hs ? R_RESP : R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef CORE_C1_SB_SRAM_RANGE_CHK_EN
    logic w_err_q;
    assign sb_bresp = w_err_q;
`else
    assign sb_bresp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_cnt   <= 4'd0;
`ifdef CORE_C1_SB_SRAM_RANGE_CHK_EN
            w_err_q <= 1'b0;
`endif
        end else begin
`ifdef CORE_C1_SB_SRAM_RANGE_CHK_EN
            if (w_hs) w_err_q <= w_oor;
`endif
            case (w_state)
                W_IDLE: if (w_hs) begin
                    w_state <= (WR_WAIT == 0) ? W_RESP : W_WAIT;
                    w_cnt   <= WR_CNT_INIT;
                end
                W_WAIT: if (w_cnt == 4'd0) w_state <= W_RESP;
                        else w_cnt <= w_cnt - 4'd1;
                W_RESP: if (sb_bready) w_state <= w_hs ? W_RESP : W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_c1_sb_sram.sv
// Scoreboard bench for core_c1_sb_sram: one zero-wait instance and one with RD_WAIT=3, WR_WAIT=2.
module tb_core_c1_sb_sram;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Zero-wait instance signals
    logic        arvalid0 = 0, rready0 = 1, wvalid0 = 0, bready0 = 1;
    logic [31:0] araddr0 = 0, waddr0 = 0, wdata0 = 0;
    logic [3:0]  wstrb0 = 0;
    logic        arready0, rvalid0, wready0, bvalid0, bresp0;
    logic [31:0] rdata0;

    // Wait-state instance signals
    logic        arvalid1 = 0, rready1 = 1, wvalid1 = 0, bready1 = 1;
    logic [31:0] araddr1 = 0, waddr1 = 0, wdata1 = 0;
    logic [3:0]  wstrb1 = 0;
    logic        arready1, rvalid1, wready1, bvalid1, bresp1;
    logic [31:0] rdata1;

    logic [31:0] rq0[$], rq1[$];
    logic        bq0[$], bq1[$];

    core_c1_sb_sram #(.MEM_AW(12), .RD_WAIT(0), .WR_WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .sb_arvalid(arvalid0), .sb_arready(arready0), .sb_araddr(araddr0),
        .sb_rvalid(rvalid0), .sb_rready(rready0), .sb_rdata(rdata0),
        .sb_wvalid(wvalid0), .sb_wready(wready0), .sb_waddr(waddr0),
        .sb_wdata(wdata0), .sb_wstrb(wstrb0),
        .sb_bvalid(bvalid0), .sb_bready(bready0), .sb_bresp(bresp0)
    );

    core_c1_sb_sram #(.MEM_AW(12), .RD_WAIT(3), .WR_WAIT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .sb_arvalid(arvalid1), .sb_arready(arready1), .sb_araddr(araddr1),
        .sb_rvalid(rvalid1), .sb_rready(rready1), .sb_rdata(rdata1),
        .sb_wvalid(wvalid1), .sb_wready(wready1), .sb_waddr(waddr1),
        .sb_wdata(wdata1), .sb_wstrb(wstrb1),
        .sb_bvalid(bvalid1), .sb_bready(bready1), .sb_bresp(bresp1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report_extra(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: response %h with nothing expected", name, act);
    endtask

    // Monitor: pops the scoreboard whenever a response handshake will occur at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid0 && rready0) begin
                if (rq0.size() == 0) report_extra("r0_extra", rdata0);
                else check("r0_rdata", rdata0, rq0.pop_front());
            end
            if (bvalid0 && bready0) begin
                if (bq0.size() == 0) report_extra("b0_extra", {31'h0, bresp0});
                else check("b0_bresp", {31'h0, bresp0}, {31'h0, bq0.pop_front()});
            end
            if (rvalid1 && rready1) begin
                if (rq1.size() == 0) report_extra("r1_extra", rdata1);
                else check("r1_rdata", rdata1, rq1.pop_front());
            end
            if (bvalid1 && bready1) begin
                if (bq1.size() == 0) report_extra("b1_extra", {31'h0, bresp1});
                else check("b1_bresp", {31'h0, bresp1}, {31'h0, bq1.pop_front()});
            end
        end
    end

    // Tasks start and end #1 after a rising edge.
    task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic err);
        int n;
        waddr0 = a; wdata0 = d; wstrb0 = s; wvalid0 = 1'b1;
        bq0.push_back(err);
        n = 0;
        @(negedge clk);
        while (!wready0 && n < 20) begin @(negedge clk); n++; end
        check("wr0_wready", {31'h0, wready0}, 32'h1);
        @(posedge clk); #1;
        wvalid0 = 1'b0;
        @(negedge clk);
        check("wr0_bvalid_lat", {31'h0, bvalid0}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic rd0(input logic [31:0] a, input logic [31:0] exp);
        int n;
        araddr0 = a; arvalid0 = 1'b1;
        rq0.push_back(exp);
        n = 0;
        @(negedge clk);
        while (!arready0 && n < 20) begin @(negedge clk); n++; end
        check("rd0_arready", {31'h0, arready0}, 32'h1);
        @(posedge clk); #1;
        arvalid0 = 1'b0;
        @(negedge clk);
        check("rd0_rvalid_lat", {31'h0, rvalid0}, 32'h1);
        @(posedge clk); #1;
    endtask

    // Counts negedges after a handshake edge until rvalid1/bvalid1 first rise.
    task automatic lat1(output int r_lat, output int b_lat);
        r_lat = 0; b_lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rvalid1 && r_lat == 0) r_lat = c;
            if (bvalid1 && b_lat == 0) b_lat = c;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_lat, b_lat;

        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", {31'h0, arready0}, 32'h1);
        check("rst_wready",  {31'h0, wready0},  32'h1);
        check("rst_rvalid",  {31'h0, rvalid0},  32'h0);
        check("rst_bvalid",  {31'h0, bvalid0},  32'h0);
        check("rst_bresp",   {31'h0, bresp0},   32'h0);
        check("rst_rdata",   rdata0,            32'h0);
        check("rst1_rvalid", {31'h0, rvalid1},  32'h0);
        check("rst1_bvalid", {31'h0, bvalid1},  32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read
        wr0(32'h10, 32'hA5A5_1234, 4'hF, 1'b0);
        rd0(32'h10, 32'hA5A5_1234);

        // Byte strobes
        wr0(32'h20, 32'h1122_3344, 4'hF, 1'b0);
        wr0(32'h20, 32'hFFFF_FFFF, 4'b0101, 1'b0);
        rd0(32'h20, 32'h11FF_33FF);
        wr0(32'h24, 32'hCAFE_F00D, 4'h0, 1'b0);
        wr0(32'h24, 32'h0BAD_0001, 4'hF, 1'b0);
        wr0(32'h24, 32'hFFFF_FFFF, 4'h0, 1'b0);
        rd0(32'h27, 32'h0BAD_0001);

        // Back-to-back reads with arvalid held
        wr0(32'h0, 32'h0000_1000, 4'hF, 1'b0);
        wr0(32'h4, 32'h0000_2004, 4'hF, 1'b0);
        wr0(32'h8, 32'h0000_3008, 4'hF, 1'b0);
        arvalid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            araddr0 = 32'(4 * i);
            rq0.push_back(32'h0000_1000 + 32'h1004 * 32'(i));
            @(negedge clk);
            check("b2b_arready", {31'h0, arready0}, 32'h1);
            if (i > 0) check("b2b_rvalid", {31'h0, rvalid0}, 32'h1);
            @(posedge clk); #1;
        end
        arvalid0 = 1'b0;
        @(negedge clk);
        check("b2b_rvalid_last", {31'h0, rvalid0}, 32'h1);
        @(posedge clk); #1;

        // Read stall with a pending AR
        wr0(32'h30, 32'h5EED_0030, 4'hF, 1'b0);
        rready0 = 1'b0;
        araddr0 = 32'h30; arvalid0 = 1'b1;
        rq0.push_back(32'h5EED_0030);
        @(posedge clk); #1;
        araddr0 = 32'h0;
        rq0.push_back(32'h0000_1000);
        repeat (3) begin
            @(negedge clk);
            check("stall_rvalid",  {31'h0, rvalid0},  32'h1);
            check("stall_rdata",   rdata0,            32'h5EED_0030);
            check("stall_arready", {31'h0, arready0}, 32'h0);
            @(posedge clk); #1;
        end
        rready0 = 1'b1;
        @(negedge clk);
        check("stall_release_arready", {31'h0, arready0}, 32'h1);
        @(posedge clk); #1;
        arvalid0 = 1'b0;
        @(negedge clk);
        check("stall_next_rvalid", {31'h0, rvalid0}, 32'h1);
        @(posedge clk); #1;

        // Wait-state instance: write latency
        waddr1 = 32'h40; wdata1 = 32'hDEAD_BEEF; wstrb1 = 4'hF; wvalid1 = 1'b1;
        bq1.push_back(1'b0);
        @(negedge clk);
        check("ws_wready", {31'h0, wready1}, 32'h1);
        @(posedge clk); #1;
        wvalid1 = 1'b0;
        lat1(r_lat, b_lat);
        check("ws_b_lat", 32'(b_lat), 32'd3);

        // Same-cycle read and write to 0x40: read sees old value
        araddr1 = 32'h40; arvalid1 = 1'b1;
        waddr1 = 32'h40; wdata1 = 32'h1234_5678; wstrb1 = 4'hF; wvalid1 = 1'b1;
        rq1.push_back(32'hDEAD_BEEF);
        bq1.push_back(1'b0);
        @(negedge clk);
        check("ws_both_ready", {30'h0, arready1, wready1}, 32'h3);
        @(posedge clk); #1;
        arvalid1 = 1'b0; wvalid1 = 1'b0;
        lat1(r_lat, b_lat);
        check("ws_r_lat", 32'(r_lat), 32'd4);
        check("ws_b_lat2", 32'(b_lat), 32'd3);

        araddr1 = 32'h40; arvalid1 = 1'b1;
        rq1.push_back(32'h1234_5678);
        @(negedge clk);
        check("ws_arready2", {31'h0, arready1}, 32'h1);
        @(posedge clk); #1;
        arvalid1 = 1'b0;
        lat1(r_lat, b_lat);
        check("ws_r_lat2", 32'(r_lat), 32'd4);

`ifdef CORE_C1_SB_SRAM_RANGE_CHK_EN
        // Out-of-range accesses
        wr0(32'h0, 32'hCAFE_0001, 4'hF, 1'b0);
        wr0(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
        rd0(32'h0, 32'hCAFE_0001);
        rd0(32'h0001_0000, 32'h0);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("rq0_drained", 32'(rq0.size()), 32'd0);
        check("bq0_drained", 32'(bq0.size()), 32'd0);
        check("rq1_drained", 32'(rq1.size()), 32'd0);
        check("bq1_drained", 32'(bq1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
